jtag_mem_ctrl: RTL

JTAG-to-memory access controller for a BSCANE2 USER data register. It decodes commands shifted in through the scan chain and runs single-word read and write transactions on a simple request/acknowledge memory port. It returns status, address and read data on the next DR capture, and enforces a timeout on the memory side. It sits between a BSCANE2 primitive's fabric outputs and an on-chip memory or register bank, all in the buffered TCK domain.

---
 rtl/jtag_mem_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jtag_mem_ctrl.sv
// JTAG-to-memory access controller behind a BSCANE2 USER data register.
// Decodes scanned commands into single-word req/ack memory transactions, all in the TCK domain.
module jtag_mem_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          TCK,
  input  logic          rst_top,
  input  logic          SEL,
  input  logic          CAPTURE,
  input  logic          SHIFT,
  input  logic          UPDATE,
  input  logic          RESET,
  input  logic          TDI,
  output logic          TDO,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int        L    = 2 + AW + DW;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OP_CLR = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_RD_INC = 2'b11} op_t;

  state_t        state;
  logic [L-1:0]  sr;
  logic          err;
  logic [AW-1:0] addr_ptr;
  logic [DW-1:0] rdata_q;
  logic [15:0]   cnt;
  logic          auto_inc;

  op_t           cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  assign cmd_op   = op_t'(sr[L-1:L-2]);
  assign cmd_addr = sr[L-3:DW];
  assign cmd_data = sr[DW-1:0];

  // TDO must present sr[0] before the shift edge, so it stays combinational.
  assign TDO  = sr[0];
  assign busy = (state != IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge TCK or negedge rst_top) begin
    if (!rst_top) begin
      sr <= '0;
    end else if (SEL && CAPTURE) begin
      sr <= {err, busy, addr_ptr, rdata_q};
    end else if (SEL && SHIFT) begin
      sr <= {TDI, sr[L-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge rst_top) begin
    if (!rst_top) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      addr_ptr  <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
      auto_inc  <= 1'b0;
    end else if (RESET) begin
      // Test-Logic-Reset aborts the access but keeps err, addr_ptr and rdata_q.
      state   <= IDLE;
      mem_req <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (SEL && UPDATE) begin
            case (cmd_op)
              OP_CLR: err <= 1'b0;
              OP_WR: begin
                mem_we    <= 1'b1;
                mem_addr  <= cmd_addr;
                mem_wdata <= cmd_data;
                addr_ptr  <= cmd_addr;
              end
              OP_RD: begin
                mem_we   <= 1'b0;
                mem_addr <= cmd_addr;
                addr_ptr <= cmd_addr;
              end
              OP_RD_INC: begin
                mem_we   <= 1'b0;
                mem_addr <= addr_ptr;
              end
            endcase
            if (cmd_op != OP_CLR) begin
              state    <= ACCESS;
              mem_req  <= 1'b1;
              cnt      <= '0;
              auto_inc <= (cmd_op == OP_RD_INC);
            end
          end
        end
        ACCESS: begin
          if (SEL && UPDATE) err <= 1'b1;
          // An ack on the final timeout edge takes priority over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (!mem_we) rdata_q <= mem_rdata;
          end else if (cnt == LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (SEL && UPDATE) err <= 1'b1;
          if (auto_inc) addr_ptr <= addr_ptr + AW'(1);
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
